alu_operand_loader: RTL and testbench
=====================================

Name: alu_operand_loader

Overview:
- Upstream input stage of the 4-bit ALU.
- Captures operand A, operand B and a 2-bit operation select from the board's 4 slide switches, one value per press of a single load button.
- Drives the operand buses and the select lines of the 4:1 result multiplexer in the ALU.
- Button inputs are synchronized and debounced internally; the block flags when a complete operand/opcode set is held.

Parameters:
- WIDTH, 4, operand and switch width in bits.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level change; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sw  input  WIDTH  slide-switch value, sampled directly with no synchronizer; must be held static around a press.
- btn_load  input  1  asynchronous load pushbutton, active-high.
- btn_clear  input  1  asynchronous clear pushbutton, active-high.
- a_o  output  WIDTH  captured operand A.
- b_o  output  WIDTH  captured operand B.
- sel_o  output  2  captured operation select for the ALU result mux.
- valid_o  output  1  high when A, B and the select are all captured (state READY).
- state_o  output  2  current FSM state: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3.

Behaviour:
- Reset: one clock edge with rst=1 forces the following, regardless of any operation in progress:
  - state LOAD_A; a_o, b_o, sel_o = 0; valid_o = 0.
  - sync flops, debounced level, delayed debounced level and debounce counter all cleared to 0.
- Synchronizers: btn_load and btn_clear each pass through a 2-flop synchronizer, giving load_s and clear_s.
- Debounce, load path only:
  - The counter increments on each edge where load_s differs from the debounced level db.
  - The counter resets to 0 on any edge where load_s equals db.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and load_s still differs, db takes load_s and the counter clears.
  - Counter width is ceil(log2(DEBOUNCE_CYCLES+1)).
- Load pulse:
  - db_d is a registered copy of db; load_p = db & ~db_d.
  - load_p is high for exactly one cycle per accepted press.
  - Releasing the button produces no pulse.
- Latency: if btn_load is first sampled high at edge k and stays high, the capture edge is k+DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES cycles after synchronization produces no pulse.
- FSM, on edges where load_p=1 and clear_s=0:
  - LOAD_A: a_o <= sw; go to LOAD_B.
  - LOAD_B: b_o <= sw; go to LOAD_OP.
  - LOAD_OP: sel_o <= sw[1:0]; sw[WIDTH-1:2] ignored; go to READY.
  - READY: go to LOAD_A and valid_o <= 0. a_o, b_o and sel_o hold their old values until each is overwritten.
- With no pulse, all registers hold.
- valid_o is registered: it rises on the same edge that enters READY and falls on the edge that leaves READY.
- Clear: on any edge with clear_s=1:
  - state LOAD_A; a_o, b_o, sel_o, valid_o = 0.
  - Debounce logic keeps running.
  - Clear is level-sensitive and not debounced.
  - Outputs reach zero at edge k+2 when btn_clear is first sampled high at edge k.
- Simultaneous load_p and clear_s: clear wins; the press is consumed and lost.
- Button held through a reset release: db restarts at 0, so the held button counts as a new press once debounced.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset check: assert rst for 1 edge while sw=4'hF and both buttons are high; release buttons, then rst -> all outputs 0, state_o=0; no capture until a fresh press.
- Full load: presses with sw=4'h5, 4'hA, then 4'h2 (each held ≥8 cycles, released ≥8 cycles).
  - Result: a_o=5, b_o=A, sel_o=2, valid_o=1, state_o=3.
  - The first capture occurs exactly 6 edges after btn_load is first sampled high.
- Bounce rejection: btn_load toggles high 2 cycles / low 1 cycle ×5, then stays low -> no state change.
  - Then hold high 10 cycles -> exactly one capture.
- Restart from READY: after the full-load case, one press with sw=4'h7 -> state_o=0, valid_o=0, a_o=5 unchanged.
  - The next press gives a_o=7.
- Clear mid-load: in LOAD_OP with a_o=3, b_o=9, pulse btn_clear for 3 cycles -> all outputs 0, state_o=0 two edges after the first sampled high.
- Clear/load collision: align btn_clear so clear_s is high on the load_p cycle in LOAD_B -> state_o=0, b_o=0; no capture.

Source files
------------

// File: rtl/alu_operand_loader.sv
// Operand/opcode input stage for the 4-bit ALU: captures A, B and the mux select
// from the slide switches, one value per debounced press of the load button.
module alu_operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [1:0]       sel_o,
  output logic             valid_o,
  output logic [1:0]       state_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  logic             load_meta_q, load_meta_d;
  logic             load_sync_q, load_sync_d;
  logic             clear_meta_q, clear_meta_d;
  logic             clear_sync_q, clear_sync_d;
  logic             db_q, db_d;
  logic             db_dly_q, db_dly_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             load_p;

  // A level change is accepted only after the synchronized input has disagreed
  // with the debounced level for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    load_meta_d  = btn_load;
    load_sync_d  = load_meta_q;
    clear_meta_d = btn_clear;
    clear_sync_d = clear_meta_q;
    db_dly_d     = db_q;
    db_d         = db_q;
    cnt_d        = '0;
    if (load_sync_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d = load_sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign load_p = db_q & ~db_dly_q;

  // Clear takes priority, so a press landing on a clear cycle is dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    if (clear_sync_q) begin
      state_d = LOAD_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = '0;
      valid_d = 1'b0;
    end else if (load_p) begin
      case (state_q)
        LOAD_A: begin
          a_d     = sw;
          state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d     = sw;
          state_d = LOAD_OP;
        end
        LOAD_OP: begin
          sel_d   = sw[1:0];
          valid_d = 1'b1;
          state_d = READY;
        end
        READY: begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
        default: begin
          valid_d = 1'b0;
          state_d = LOAD_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_meta_q  <= 1'b0;
      load_sync_q  <= 1'b0;
      clear_meta_q <= 1'b0;
      clear_sync_q <= 1'b0;
      db_q         <= 1'b0;
      db_dly_q     <= 1'b0;
      cnt_q        <= '0;
      state_q      <= LOAD_A;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      load_meta_q  <= load_meta_d;
      load_sync_q  <= load_sync_d;
      clear_meta_q <= clear_meta_d;
      clear_sync_q <= clear_sync_d;
      db_q         <= db_d;
      db_dly_q     <= db_dly_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      valid_q      <= valid_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sel_o   = sel_q;
  assign valid_o = valid_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window; expected
// operand/state records are queued when a press is driven and popped on capture.
module tb_alu_operand_loader;

  localparam int WIDTH = 4;
  localparam int DB    = 4;
  localparam int LAT   = DB + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sw;
  logic             btn_load;
  logic             btn_clear;
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic [1:0]       sel_o;
  logic             valid_o;
  logic [1:0]       state_o;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] st;
  } exp_t;

  exp_t sbq[$];

  logic [3:0] mA, mB;
  logic [1:0] mSel, mState;
  logic       mValid;

  alu_operand_loader #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
    .a_o(a_o), .b_o(b_o), .sel_o(sel_o), .valid_o(valid_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushModel();
    exp_t e;
    e.a = mA; e.b = mB; e.sel = mSel; e.valid = mValid; e.st = mState;
    sbq.push_back(e);
  endtask

  task automatic modelLoad(input logic [3:0] swv);
    case (mState)
      2'd0: begin mA = swv; mState = 2'd1; end
      2'd1: begin mB = swv; mState = 2'd2; end
      2'd2: begin mSel = swv[1:0]; mValid = 1'b1; mState = 2'd3; end
      default: begin mValid = 1'b0; mState = 2'd0; end
    endcase
    pushModel();
  endtask

  task automatic modelClear();
    mA = '0; mB = '0; mSel = '0; mValid = 1'b0; mState = 2'd0;
    pushModel();
  endtask

  task automatic checkRecord(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checkOutput({tag, "_queue_empty"}, 8'd0, 8'd1);
    end else begin
      e = sbq.pop_front();
      checkOutput({tag, "_a"},     {4'd0, a_o},     {4'd0, e.a});
      checkOutput({tag, "_b"},     {4'd0, b_o},     {4'd0, e.b});
      checkOutput({tag, "_sel"},   {6'd0, sel_o},   {6'd0, e.sel});
      checkOutput({tag, "_valid"}, {7'd0, valid_o}, {7'd0, e.valid});
      checkOutput({tag, "_state"}, {6'd0, state_o}, {6'd0, e.st});
    end
  endtask

  // One clean press: measure edges from first sample to capture, then release.
  task automatic applyStimulus(input logic [3:0] swv, input string tag);
    logic [1:0] prev;
    int         n;
    bit         seen;
    modelLoad(swv);
    prev = state_o;
    sw = swv;
    btn_load = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (state_o !== prev) begin
        n = i;
        seen = 1;
        break;
      end
    end
    @(negedge clk);
    checkOutput({tag, "_latency"}, 8'(n), 8'(LAT));
    if (seen) checkRecord(tag);
    else checkOutput({tag, "_timeout"}, 8'd0, 8'd1);
    repeat (4) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; sw = 4'hF; btn_load = 1'b1; btn_clear = 1'b1;
    mA = '0; mB = '0; mSel = '0; mValid = 1'b0; mState = 2'd0;
    @(negedge clk);
    btn_load = 1'b0; btn_clear = 1'b0;
    rst = 1'b0;
    pushModel();
    checkRecord("reset");
    repeat (12) @(negedge clk);
    checkOutput("reset_no_capture", {6'd0, state_o}, 8'd0);

    $display("[TB] full load");
    applyStimulus(4'h5, "load_a");
    applyStimulus(4'hA, "load_b");
    applyStimulus(4'h2, "load_op");

    $display("[TB] restart from READY");
    applyStimulus(4'h7, "restart");
    applyStimulus(4'h7, "reload_a");

    $display("[TB] bounce rejection");
    sw = 4'hC;
    for (int i = 0; i < 5; i++) begin
      btn_load = 1'b1;
      repeat (2) @(negedge clk);
      btn_load = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkOutput("bounce_state", {6'd0, state_o}, {6'd0, mState});
    checkOutput("bounce_b", {4'd0, b_o}, {4'd0, mB});
    applyStimulus(4'h9, "bounce_hold");
    repeat (6) @(negedge clk);
    checkOutput("bounce_single", {6'd0, state_o}, 8'd2);

    $display("[TB] clear mid-load");
    applyStimulus(4'h1, "to_ready");
    applyStimulus(4'h1, "to_load_a");
    applyStimulus(4'h3, "pre_clear_a");
    applyStimulus(4'h9, "pre_clear_b");
    btn_clear = 1'b1;
    modelClear();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("clear_not_yet", {6'd0, state_o}, 8'd2);
    @(negedge clk);
    @(negedge clk);
    checkRecord("clear");
    btn_clear = 1'b0;
    repeat (6) @(negedge clk);

    $display("[TB] clear/load collision");
    applyStimulus(4'h4, "coll_pre_a");
    sw = 4'h6;
    btn_load = 1'b1;
    modelClear();
    repeat (4) @(negedge clk);
    btn_clear = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0;
    repeat (2) @(negedge clk);
    checkRecord("collision");
    repeat (4) @(negedge clk);
    btn_load = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("collision_lost", {6'd0, state_o}, 8'd0);
    checkOutput("collision_b", {4'd0, b_o}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
